id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline register for the 5-stage pipeline. It sits directly downstream of `control_unit` and captures that block's 10-bit `signals` vector together with the operands, immediate and destination register. It owns the NZCV flag register and evaluates the 4-bit ARM condition field at issue. An instruction whose condition fails, or that is flushed, enters EX as a bubble.

## Interface
- `DATA_W`, default 32: operand and immediate width.
- `REG_W`, default 4: register index width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `id_valid`  in  1  decode holds a real instruction this cycle.
- `stall`  in  1  hold the EX register contents (hazard unit).
- `flush`  in  1  kill the decode instruction (branch taken).
- `id_signals`  in  10  `control_unit` output; bit map is in Structure.
- `id_condition`  in  4  instruction [31:28].
- `id_rn`, `id_rm`  in  DATA_W  register-file read data.
- `id_imm`  in  DATA_W  extended immediate.
- `id_rd`  in  REG_W  destination register.
- `flags_we`  in  1  EX result updates flags (S bit).
- `flags_in`  in  4  NZCV from the EX ALU.
- `ex_valid`  out  1  EX holds a live instruction.
- `ex_signals`  out  10  registered control; all-zero for a bubble.
- `ex_rn`, `ex_rm`, `ex_imm`  out  DATA_W  registered operands.
- `ex_rd`  out  REG_W  registered destination.
- `flags`  out  4  architectural NZCV, [3]=N … [0]=V.
- `squash_cnt`  out  16  count of condition-failed instructions.

## Operation
- Condition evaluation uses the effective flags. Effective flags are `flags_in` when `flags_we`=1 (same-cycle bypass), otherwise `flags`.
- Condition codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL always; 15 never (fails).
- On each edge, priority is reset > flush > stall > load.
  - flush: `ex_valid`←0 and `ex_signals`←0. Data fields are don't-care; hold them.
  - stall (no flush): all `ex_*` registers hold.
  - load, when `id_valid` and the condition passes: capture all `id_*` fields and set `ex_valid`←1.
  - load, when `id_valid` and the condition fails: capture a bubble (`ex_valid`←0, `ex_signals`←0) and increment `squash_cnt`.
  - load, when `!id_valid`: capture a bubble; the counter is unchanged.
- Flag register: `flags`←`flags_in` whenever `flags_we`=1. This is independent of stall and flush, because flags belong to the EX instruction.
- `squash_cnt` wraps 0xFFFF→0x0000. It does not count while stalled or flushed.
- An all-zero `ex_signals` encodes: regwrite 0, mem read/write 0, branch 0, so a bubble is architecturally inert.

## Timing
- Latency is 1 cycle from decode inputs to `ex_*` outputs. All outputs are registered; there are no combinational in→out paths.
- Reset values: `ex_valid` 0, `ex_signals` 0, `ex_rn`/`ex_rm`/`ex_imm` 0, `ex_rd` 0, `flags` 4'b0000, `squash_cnt` 0.
- With `flags` = 0000 after reset, EQ fails and NE passes.
- Stall and flush in the same cycle: flush wins, producing a bubble.
- `flags_we` in the same cycle as a conditional instruction in decode: the new flags decide that instruction. No stall is needed.
- Reset asserted mid-stall clears everything; stall has no effect during reset.

## Structure
- Shared package `pipe_pkg` holds:
  - Format codes: ALU 2'b00, LS 2'b01, BR 2'b10.
  - Condition-code constants EQ…NV.
  - `signals` bit indices:
    - [1:0] alu_op (00 add, 01 sub, 11 and, 10 or)
    - [2] sext_sel
    - [3] imm_sel
    - [4] set_flags
    - [6:5] mem rd/wr
    - [7] wb_sel
    - [8] reg_write
    - [9] branch
- One combinational sub-module, `cond_check`: inputs condition[3:0] and nzcv[3:0], output pass. It is instantiated once, on the effective flags.

## Test plan
- Reset then `id_valid`=1, AL, `id_signals`=0x114, `id_rn`=5, `id_rm`=7 → next cycle `ex_valid`=1, `ex_signals`=0x114, `ex_rn`=5, `ex_rm`=7.
- After reset (flags 0000), issue EQ → `ex_valid`=0, `ex_signals`=0, `squash_cnt`=1. Then issue NE → `ex_valid`=1.
- `flags_we`=1, `flags_in`=4'b0100 in the same cycle as an EQ instruction → instruction passes and `flags`=0100 next cycle.
- Load instruction A, then hold `stall`=1 for 3 cycles while changing `id_*` → `ex_*` equal A throughout. `flags_we` still updates `flags`.
- `stall`=1 and `flush`=1 together → `ex_valid`=0, `ex_signals`=0, `squash_cnt` unchanged.
- Preload the counter condition to 0xFFFF squashes, then fail one more (NV) → `squash_cnt`=0x0000. Assert reset mid-stream → all outputs 0 next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction format codes, ARM condition
// codes, ALU op encodings, control-vector bit positions and NZCV bit
// positions. Imported by the decode/execute pipeline blocks.
package pipe_pkg;

  typedef enum logic [1:0] {
    FMT_ALU = 2'b00,
    FMT_LS  = 2'b01,
    FMT_BR  = 2'b10
  } fmt_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_OR  = 2'b10,
    ALU_AND = 2'b11
  } alu_op_e;

  // control_unit signals vector layout
  localparam int unsigned SIG_W         = 10;
  localparam int unsigned SIG_ALU_OP_LO = 0;
  localparam int unsigned SIG_ALU_OP_HI = 1;
  localparam int unsigned SIG_SEXT_SEL  = 2;
  localparam int unsigned SIG_IMM_SEL   = 3;
  localparam int unsigned SIG_SET_FLAGS = 4;
  localparam int unsigned SIG_MEM_RD    = 5;
  localparam int unsigned SIG_MEM_WR    = 6;
  localparam int unsigned SIG_WB_SEL    = 7;
  localparam int unsigned SIG_REG_WRITE = 8;
  localparam int unsigned SIG_BRANCH    = 9;

  // NZCV bit positions within the 4-bit flag vector
  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator.
// Ports:
//   condition  in  4  instruction condition field [31:28]
//   nzcv       in  4  flags, [3]=N [2]=Z [1]=C [0]=V
//   pass       out 1  instruction should execute
module cond_check
  import pipe_pkg::*;
(
  input  logic [3:0] condition,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(condition))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register. Captures the control vector,
// operands, immediate and destination from decode, owns the NZCV flag
// register and turns condition-failed or flushed instructions into bubbles.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   id_valid              decode holds a real instruction
//   stall                 hold EX register contents
//   flush                 kill the decode instruction
//   id_signals[9:0]       control_unit output
//   id_condition[3:0]     instruction condition field
//   id_rn, id_rm, id_imm  operands and extended immediate
//   id_rd                 destination register index
//   flags_we, flags_in    flag update from the EX ALU
//   ex_valid              EX holds a live instruction
//   ex_signals            registered control (zero for a bubble)
//   ex_rn, ex_rm, ex_imm  registered operands
//   ex_rd                 registered destination
//   flags                 architectural NZCV
//   squash_cnt            count of condition-failed instructions
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [9:0]        id_signals,
  input  logic [3:0]        id_condition,
  input  logic [DATA_W-1:0] id_rn,
  input  logic [DATA_W-1:0] id_rm,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  output logic              ex_valid,
  output logic [9:0]        ex_signals,
  output logic [DATA_W-1:0] ex_rn,
  output logic [DATA_W-1:0] ex_rm,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rd,
  output logic [3:0]        flags,
  output logic [15:0]       squash_cnt
);

  logic [3:0] eff_flags;
  logic       cond_pass;

  // Same-cycle bypass: a flag-setting instruction in EX decides the
  // conditional instruction currently in decode without a stall.
  assign eff_flags = flags_we ? flags_in : flags;

  cond_check u_cond_check (
    .condition (id_condition),
    .nzcv      (eff_flags),
    .pass      (cond_pass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_signals <= '0;
      ex_rn      <= '0;
      ex_rm      <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      flags      <= '0;
      squash_cnt <= '0;
    end else begin
      // Flags belong to the instruction already in EX, so they update
      // regardless of stall/flush on the decode side.
      if (flags_we) begin
        flags <= flags_in;
      end

      if (flush) begin
        ex_valid   <= 1'b0;
        ex_signals <= '0;
      end else if (!stall) begin
        ex_rn  <= id_rn;
        ex_rm  <= id_rm;
        ex_imm <= id_imm;
        ex_rd  <= id_rd;
        if (id_valid && cond_pass) begin
          ex_valid   <= 1'b1;
          ex_signals <= id_signals;
        end else begin
          ex_valid   <= 1'b0;
          ex_signals <= '0;
          if (id_valid) begin
            squash_cnt <= squash_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule
